// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture
//   Receiving end of a multiplexed 7-segment display bus. Watches the segment
//   pattern and the one-hot digit select, and samples a digit once its
//   {pattern, select} pair has been stable for STABLE_CYC consecutive cycles.
//   Each sampled pattern is decoded back to BCD (dash -> 4'hE, unknown ->
//   4'hF). When every digit has been sampled at least once, the whole frame
//   is published together with a one-cycle frame_valid pulse.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_in       segment pattern {a,b,c,d,e,f,g}, active-high, bit6 = a
//   dig_sel      one-hot digit enable, bit i selects digit i
//   bcd_out      last complete frame, digit i in [4i+3:4i]
//   dash_mask    bit i set if digit i of the last frame was a dash
//   frame_valid  one-cycle pulse when the frame outputs update
//   frame_err    last frame contained at least one unrecognised pattern
// -----------------------------------------------------------------------------
module seg_capture #(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg_in,
  input  logic [NUM_DIG-1:0]   dig_sel,
  output logic [4*NUM_DIG-1:0] bcd_out,
  output logic [NUM_DIG-1:0]   dash_mask,
  output logic                 frame_valid,
  output logic                 frame_err
);

  // Reject configurations the stability counter or the select bus cannot hold.
  if (NUM_DIG < 1 || NUM_DIG > 8) begin : g_bad_num_dig
    $error("seg_capture: NUM_DIG must be in 1..8");
  end
  if (STABLE_CYC < 1 || 64'(STABLE_CYC) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_stable
    $error("seg_capture: STABLE_CYC must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic [6+NUM_DIG:0]     prev_val;
  logic [NUM_DIG-1:0]     cap_mask;
  logic [4*NUM_DIG-1:0]   shadow_nib;
  logic [NUM_DIG-1:0]     shadow_dash;
  logic [NUM_DIG-1:0]     shadow_inv;

  logic [3:0]             dec_nib;
  logic                   dec_dash;
  logic                   dec_inv;
  logic                   sel_valid;
  logic                   same_val;
  logic                   do_sample;
  logic                   mask_full;
  logic [NUM_DIG-1:0]     sample_bits;

  // Segment pattern back to BCD; dash and unknown patterns get marker nibbles.
  always_comb begin
    dec_nib  = 4'hF;
    dec_dash = 1'b0;
    dec_inv  = 1'b0;
    case (seg_in)
      7'h7E: dec_nib = 4'd0;
      7'h30: dec_nib = 4'd1;
      7'h6D: dec_nib = 4'd2;
      7'h79: dec_nib = 4'd3;
      7'h33: dec_nib = 4'd4;
      7'h5B: dec_nib = 4'd5;
      7'h5F: dec_nib = 4'd6;
      7'h70: dec_nib = 4'd7;
      7'h7F: dec_nib = 4'd8;
      7'h7B: dec_nib = 4'd9;
      7'h01: begin
        dec_nib  = 4'hE;
        dec_dash = 1'b1;
      end
      default: begin
        dec_nib = 4'hF;
        dec_inv = 1'b1;
      end
    endcase
  end

  // Stability tracking. A fresh value counts as its own first stable cycle,
  // so the sample decision uses the next counter value, not the registered one.
  // A digit is sampled once per stable run: never again while HELD.
  always_comb begin
    sel_valid = $onehot(dig_sel);
    same_val  = ({seg_in, dig_sel} == prev_val);
    cnt_next  = '0;
    if (sel_valid && same_val)
      cnt_next = (cnt == STABLE_C) ? cnt : cnt + 1'b1;
    else if (sel_valid)
      cnt_next = CNT_W'(1);
    do_sample   = sel_valid && (cnt_next == STABLE_C) && (!same_val || state != HELD);
    sample_bits = do_sample ? dig_sel : '0;
    mask_full   = &cap_mask;
  end

  // Digit qualification FSM together with the stability counter and the
  // previous-value register it compares against.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      prev_val <= '0;
    end else begin
      cnt      <= cnt_next;
      prev_val <= {seg_in, dig_sel};
      if (!sel_valid)
        state <= IDLE;
      else if (do_sample)
        state <= HELD;
      else if (!same_val)
        state <= SETTLE;
      else
        state <= state;
    end
  end

  // Shadow slots and frame publication. The frame is published on the edge
  // after the mask fills; a sample landing on that same edge seeds the next
  // frame's mask while the outputs take the shadow contents from before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_nib  <= '0;
      shadow_dash <= '0;
      shadow_inv  <= '0;
      cap_mask    <= '0;
      bcd_out     <= '0;
      dash_mask   <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (sample_bits[i]) begin
          shadow_nib[4*i +: 4] <= dec_nib;
          shadow_dash[i]       <= dec_dash;
          shadow_inv[i]        <= dec_inv;
        end
      end
      frame_valid <= mask_full;
      if (mask_full) begin
        cap_mask  <= sample_bits;
        bcd_out   <= shadow_nib;
        dash_mask <= shadow_dash;
        frame_err <= |shadow_inv;
      end else begin
        cap_mask <= cap_mask | sample_bits;
      end
    end
  end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receiving end of the 7-segment display interface: monitors a multiplexed 4-digit segment bus and turns the patterns back into BCD digits.
- Used for display loop-back checking and for reading panel data from external display drivers.
- Segment bit order a..g maps to bit6..bit0, active-high, matching the team's segment decoder.
- Captures each digit after its pattern has been stable for a set time, then publishes a complete frame with a one-cycle valid pulse and an error flag.

Parameters:
- NUM_DIG, 4, number of multiplexed digits; legal range 1..8.
- STABLE_CYC, 4, consecutive identical cycles required before a digit is sampled; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the stability counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- seg_in  input  7  segment pattern {a,b,c,d,e,f,g}; synchronous to clk, registered upstream.
- dig_sel  input  NUM_DIG  one-hot digit enable, active-high; bit i selects digit i.
- bcd_out  output  4*NUM_DIG  last complete frame; digit i occupies [4i+3:4i].
- dash_mask  output  NUM_DIG  bit i set if digit i of the last frame was a dash.
- frame_valid  output  1  one-cycle pulse when bcd_out/dash_mask/frame_err update.
- frame_err  output  1  last frame contained at least one unrecognised pattern.

Behaviour:
- Reset: asynchronous on rst_n low; every register is cleared.
  - bcd_out=0, dash_mask=0, frame_valid=0, frame_err=0.
  - Stability counter=0, capture mask=0, shadow digits=0, state=IDLE.
  - Reset mid-frame discards all partial captures.
- Decode (combinational, internal):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
  - 01 -> dash: nibble 4'hE, dash flag set.
  - Any other pattern -> invalid: nibble 4'hF, invalid flag set.
- Select qualification:
  - dig_sel is valid only when exactly one bit is set.
  - All-zero or multi-hot = blank; state goes to IDLE and the counter clears.
- Stability tracking:
  - The previous {seg_in,dig_sel} is held in a register.
  - If the current value equals the previous value and the select is valid, the counter increments, saturating at STABLE_CYC.
  - Otherwise the counter loads 1 if the select is valid, else 0.
  - The first cycle of a new value counts as 1.
- FSM:
  - IDLE: select invalid. Go to SETTLE on a valid select.
  - SETTLE: counter < STABLE_CYC.
    - When counter reaches STABLE_CYC, sample in that same cycle and go to HELD.
    - Any change of value reloads the counter and stays in SETTLE.
    - Select going invalid goes to IDLE.
  - HELD: no further sampling. Any change goes to SETTLE (counter=1) or to IDLE (invalid select).
  - With STABLE_CYC=1, sampling happens on the first cycle of every new valid value.
- Sample action:
  - Write the decoded nibble, dash flag and invalid flag into shadow slot i (index of the set dig_sel bit).
  - Set capture-mask bit i.
  - Re-capturing a digit already captured in the current frame overwrites it; latest wins and there is no error.
- Frame completion:
  - Triggered on the clock edge where the capture mask becomes all ones.
  - On the next edge:
    - bcd_out <= shadow nibbles, dash_mask <= shadow dash flags.
    - frame_err <= OR of shadow invalid flags.
    - frame_valid=1 for exactly one cycle; capture mask clears.
  - Latency: frame_valid rises 1 cycle after the completing sample.
  - A sample that occurs in the same cycle as frame_valid goes into the new frame; no loss.
- Between frames:
  - bcd_out, dash_mask and frame_err hold their values.
  - Digits are never published individually.
- Out-of-order or skipped digit scan order is irrelevant; only mask completeness matters.
- Counter width rule: STABLE_CYC must fit in CNT_W bits; this is checked at elaboration.

Test Plan:
- Scan digit0..3 with 5B,7E,30,79, each held 6 cycles, STABLE_CYC=4 -> one frame_valid pulse 1 cycle after the 4th sample. bcd_out=16'h3105, dash_mask=0, frame_err=0.
- Digit2 presents 6D for only 3 cycles, then 7F for 5 cycles -> slot2 captures 8, never 2. Frame bcd_out nibble2=8.
- Digit1 pattern 01, digit3 pattern 55 -> dash_mask=4'b0010, nibble1=E, nibble3=F, frame_err=1.
- dig_sel=4'b0011 or 4'b0000 held 20 cycles -> no capture, state IDLE, no frame_valid.
- Digit0 captured as 1, then re-presented as 9 before digits 1..3 complete -> published nibble0=9. Exactly one frame_valid.
- rst_n pulsed low after 2 of 4 digits captured -> outputs 0 immediately (asynchronous). After release, a full 4-digit scan is needed before the next frame_valid.
